rr_handshake_arbiter: RTL and testbench

- Round-robin arbiter sharing one resource among N requesters over a req/gnt/done handshake.
- Sits between requester agents and the shared resource; drives a one-hot grant and an owner index.
- Sequenced by a small FSM with a hold-time watchdog.
- Its handshake timing is what the team's req/ack assertion properties check.

---
 rtl/rr_handshake_arbiter_pkg.sv | 27 ++
 rtl/rr_handshake_arbiter_if.sv | 17 +
 rtl/rr_handshake_arbiter_priority_pick.sv | 21 ++
 rtl/rr_handshake_arbiter.sv | 131 +++++++++++++
 tb/tb_rr_handshake_arbiter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_handshake_arbiter_pkg.sv
// Shared types and the round-robin search function for the req/gnt/done arbiter.
// Holds the FSM state enum and next_rr(), which rr_priority_pick uses as its combinational core.
package rr_arb_pkg;

  localparam int MAX_N = 16;

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} arb_state_t;

  // Index of the first set request bit, searching last+1, last+2, ... modulo n.
  function automatic int next_rr(input logic [MAX_N-1:0] req, input int last, input int n);
    logic [4:0] k;
    int         sel;
    logic       found;
    sel   = 0;
    found = 1'b0;
    for (int i = 1; i <= MAX_N; i++) begin
      k = 5'(last + i);
      if (k >= 5'(n)) k = k - 5'(n);
      if (!found && (i <= n) && req[k[3:0]]) begin
        sel   = int'(k);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/rr_handshake_arbiter_if.sv
// Requester-side handshake bundle for rr_handshake_arbiter.
// The arbiter takes the master modport; requester agents take the slave modport.
interface rr_handshake_arbiter_if #(
  parameter int N = 4
) ();
  localparam int IDW = $clog2(N);

  logic [N-1:0]   req;
  logic [N-1:0]   done;
  logic [N-1:0]   gnt;
  logic           busy;
  logic [IDW-1:0] owner_id;
  logic           timeout_err;

  modport master (input req, input done, output gnt, output busy, output owner_id, output timeout_err);
  modport slave  (output req, output done, input gnt, input busy, input owner_id, input timeout_err);
endinterface

// File: rtl/rr_handshake_arbiter_priority_pick.sv
// Combinational rotate-and-find-first-set: picks the next requester after i_last.
// o_valid is low when nobody is requesting; o_idx is then 0 and must be ignored.
module rr_priority_pick
  import rr_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_last,
  output logic [IDW-1:0] o_idx,
  output logic           o_valid
);

  logic [MAX_N-1:0] w_req_ext;

  assign w_req_ext = MAX_N'(i_req);
  assign o_idx     = IDW'(next_rr(w_req_ext, int'(i_last), N));
  assign o_valid   = |i_req;

endmodule

// File: rtl/rr_handshake_arbiter.sv
// Round-robin req/gnt/done arbiter with a hold-time watchdog and a mandatory dead cycle.
// Define RR_HANDSHAKE_ARB_ASSERT_EN to compile in the handshake assertions and watchdog cover.
module rr_handshake_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  rr_handshake_arbiter_if.master bus
);

  localparam int IDW   = $clog2(N);
  localparam int CNT_W = $clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_t       r_state, w_state_nxt;
  logic [N-1:0]     r_gnt, w_gnt_nxt;
  logic [IDW-1:0]   r_owner, w_owner_nxt;
  logic [IDW-1:0]   r_last, w_last_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_timeout;
  logic [IDW-1:0]   w_pick_idx;
  logic             w_pick_valid;
  logic             w_own_done;
  logic             w_own_req;

  rr_priority_pick #(.N(N), .IDW(IDW)) u_pick (
    .i_req   (bus.req),
    .i_last  (r_last),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  assign w_own_done = bus.done[r_owner];
  assign w_own_req  = bus.req[r_owner];

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_timeout   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = {{(N-1){1'b0}}, 1'b1} << w_pick_idx;
          w_owner_nxt = w_pick_idx;
          w_cnt_nxt   = '0;
        end
      end
      GRANT: begin
        // Completion and abandon take precedence over the watchdog limit.
        if (w_own_done || !w_own_req) begin
          w_state_nxt = RELEASE;
          w_gnt_nxt   = '0;
        end else if (r_cnt == HOLD_LAST) begin
          w_state_nxt = RELEASE;
          w_gnt_nxt   = '0;
          w_timeout   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      RELEASE: begin
        w_state_nxt = IDLE;
        w_last_nxt  = r_owner;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_owner <= '0;
      r_last  <= IDW'(N - 1);
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign bus.gnt         = r_gnt;
  assign bus.busy        = (r_state != IDLE);
  assign bus.owner_id    = r_owner;
  assign bus.timeout_err = w_timeout;

`ifdef RR_HANDSHAKE_ARB_ASSERT_EN
  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.gnt))
    $info("%0t a_gnt_onehot0 held", $time);
    else $error("%0t gnt not onehot0: %b", $time, bus.gnt);

  for (genvar k = 0; k < N; k++) begin : g_sva
    a_gnt_needs_req: assert property (@(posedge clk) disable iff (!rst_n)
      $rose(bus.gnt[k]) |-> bus.req[k])
      $info("%0t a_gnt_needs_req[%0d] held", $time, k);
      else $error("%0t grant %0d without request", $time, k);

    a_done_drops_gnt: assert property (@(posedge clk) disable iff (!rst_n)
      bus.gnt[k] && bus.done[k] |=> !bus.gnt[k])
      $info("%0t a_done_drops_gnt[%0d] held", $time, k);
      else $error("%0t grant %0d held after done", $time, k);

    a_hold_bounded: assert property (@(posedge clk) disable iff (!rst_n)
      $rose(bus.gnt[k]) |-> ##[1:MAX_HOLD] !bus.gnt[k])
      $info("%0t a_hold_bounded[%0d] held", $time, k);
      else $error("%0t grant %0d exceeded hold limit", $time, k);
  end

  c_watchdog: cover property (@(posedge clk) disable iff (!rst_n) bus.timeout_err)
    $info("%0t watchdog release covered", $time);
`else
  // Assertions compiled out; the RTL above is unchanged.
`endif

endmodule

// File: tb/tb_rr_handshake_arbiter.sv
// Self-checking bench for rr_handshake_arbiter (N=4, MAX_HOLD=8): constant vector table,
// hand-written corner sequences, then randomized traffic against a behavioural model.
module tb_rr_handshake_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  rr_handshake_arbiter_if #(.N(N)) bus ();

  rr_handshake_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL sim_time_limit: run did not end within the time bound");
    $fatal(1, "time limit");
  end

  typedef struct {
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic       busy;
    logic [1:0] owner;
    logic       terr;
  } vec_t;

  vec_t tbl[21];

  // Behavioural model: who holds the resource, for how many cycles, and whether
  // the mandatory dead cycle is in progress.
  int m_owner;   // -1 when nobody holds a grant
  int m_oid;
  int m_last;
  int m_hold;    // cycles granted so far, counting the current one
  bit m_dead;

  function automatic void model_reset();
    m_owner = -1;
    m_oid   = 0;
    m_last  = N - 1;
    m_hold  = 0;
    m_dead  = 1'b0;
  endfunction

  function automatic logic [3:0] m_gnt();
    return (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
  endfunction

  function automatic logic m_busy();
    return (m_owner >= 0) || m_dead;
  endfunction

  function automatic logic m_terr(input logic [3:0] r, input logic [3:0] d);
    if (m_owner < 0) return 1'b0;
    return (m_hold == MAX_HOLD) && !d[2'(m_owner)] && r[2'(m_owner)];
  endfunction

  function automatic void model_step(input logic [3:0] r, input logic [3:0] d);
    bit found;
    int k;
    if (m_owner >= 0) begin
      if (d[2'(m_owner)] || !r[2'(m_owner)] || (m_hold == MAX_HOLD)) begin
        m_last  = m_owner;
        m_owner = -1;
        m_dead  = 1'b1;
      end else begin
        m_hold++;
      end
    end else if (m_dead) begin
      m_dead = 1'b0;
    end else begin
      found = 1'b0;
      for (int i = 1; i <= N; i++) begin
        k = (m_last + i) % N;
        if (!found && r[2'(k)]) begin
          found   = 1'b1;
          m_owner = k;
          m_oid   = k;
          m_hold  = 1;
        end
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs after a negedge, compare outputs 1ns later, then advance one clock.
  task automatic vec(input string tag, input logic [3:0] r, input logic [3:0] d,
                     input logic [3:0] eg, input logic eb, input logic [1:0] eo, input logic et);
    bus.req  = r;
    bus.done = d;
    #1;
    check({tag, " gnt"},         32'(bus.gnt),         32'(eg));
    check({tag, " busy"},        32'(bus.busy),        32'(eb));
    check({tag, " owner_id"},    32'(bus.owner_id),    32'(eo));
    check({tag, " timeout_err"}, 32'(bus.timeout_err), 32'(et));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.done = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [3:0] r;
    logic [3:0] d;

    rst_n    = 1'b0;
    bus.req  = '0;
    bus.done = '0;
    model_reset();

    // Rotation with req=1111 held; each owner completes on its 2nd grant cycle.
    tbl[0]  = '{4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{4'b1111, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0};
    tbl[2]  = '{4'b1111, 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0};
    tbl[3]  = '{4'b1111, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b0};
    tbl[4]  = '{4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[5]  = '{4'b1111, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0};
    tbl[6]  = '{4'b1111, 4'b0010, 4'b0010, 1'b1, 2'd1, 1'b0};
    tbl[7]  = '{4'b1111, 4'b0000, 4'b0000, 1'b1, 2'd1, 1'b0};
    tbl[8]  = '{4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b0};
    tbl[9]  = '{4'b1111, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0};
    tbl[10] = '{4'b1111, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b0};
    tbl[11] = '{4'b1111, 4'b0000, 4'b0000, 1'b1, 2'd2, 1'b0};
    tbl[12] = '{4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0};
    tbl[13] = '{4'b1111, 4'b0000, 4'b1000, 1'b1, 2'd3, 1'b0};
    tbl[14] = '{4'b1111, 4'b1000, 4'b1000, 1'b1, 2'd3, 1'b0};
    tbl[15] = '{4'b1111, 4'b0000, 4'b0000, 1'b1, 2'd3, 1'b0};
    tbl[16] = '{4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd3, 1'b0};
    tbl[17] = '{4'b1111, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0};
    tbl[18] = '{4'b0000, 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0};
    tbl[19] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b0};
    tbl[20] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};

    // Reset state while rst_n is held low.
    @(negedge clk);
    #1;
    check("reset gnt",         32'(bus.gnt),         32'd0);
    check("reset busy",        32'(bus.busy),        32'd0);
    check("reset owner_id",    32'(bus.owner_id),    32'd0);
    check("reset timeout_err", 32'(bus.timeout_err), 32'd0);

    do_reset();
    for (int i = 0; i < 21; i++)
      vec($sformatf("rot[%0d]", i), tbl[i].req, tbl[i].done, tbl[i].gnt, tbl[i].busy,
          tbl[i].owner, tbl[i].terr);

    // Single requester.
    do_reset();
    vec("single0", 4'b0010, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
    vec("single1", 4'b0010, 4'b0010, 4'b0010, 1'b1, 2'd1, 1'b0);
    vec("single2", 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd1, 1'b0);
    vec("single3", 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b0);

    // Watchdog: req[2] held with no done for the full hold window.
    do_reset();
    vec("wdog_idle", 4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
    for (int c = 1; c <= MAX_HOLD; c++)
      vec($sformatf("wdog_hold%0d", c), 4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2, (c == MAX_HOLD));
    vec("wdog_release", 4'b1100, 4'b0000, 4'b0000, 1'b1, 2'd2, 1'b0);
    vec("wdog_idle2",   4'b1100, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0);
    vec("wdog_next",    4'b1100, 4'b0000, 4'b1000, 1'b1, 2'd3, 1'b0);

    // Collision: stray done from a non-owner, then done on the watchdog cycle.
    do_reset();
    vec("coll_idle",  4'b0010, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
    vec("coll_stray", 4'b0010, 4'b1000, 4'b0010, 1'b1, 2'd1, 1'b0);
    for (int c = 2; c < MAX_HOLD; c++)
      vec($sformatf("coll_hold%0d", c), 4'b0010, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0);
    vec("coll_limit", 4'b0010, 4'b0010, 4'b0010, 1'b1, 2'd1, 1'b0);
    vec("coll_rel",   4'b0010, 4'b0000, 4'b0000, 1'b1, 2'd1, 1'b0);
    vec("coll_end",   4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b0);

    // Abandon: owner 0 drops req mid-grant; next pick starts after requester 0.
    do_reset();
    vec("aband_idle", 4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
    vec("aband_g1",   4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0);
    vec("aband_drop", 4'b0000, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0);
    vec("aband_rel",  4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b0);
    vec("aband_idle2",4'b0011, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
    vec("aband_next", 4'b0011, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0);

    // Reset mid-grant: outputs clear before the next edge, priority restarts at 0.
    do_reset();
    vec("rstmid_idle", 4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
    vec("rstmid_g",    4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid async gnt",         32'(bus.gnt),         32'd0);
    check("rstmid async busy",        32'(bus.busy),        32'd0);
    check("rstmid async owner_id",    32'(bus.owner_id),    32'd0);
    check("rstmid async timeout_err", 32'(bus.timeout_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    vec("rstmid_idle2", 4'b0101, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
    vec("rstmid_first", 4'b0101, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0);

    // Randomized traffic against the behavioural model.
    do_reset();
    r = 4'b0000;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 3) == 0) r = r ^ (4'b0001 << b);
      d = 4'b0000;
      if (m_owner >= 0 && $urandom_range(0, 5) == 0) d = d | (4'b0001 << m_owner);
      if ($urandom_range(0, 4) == 0) d = d | 4'($urandom_range(0, 15));
      vec($sformatf("rand[%0d]", n), r, d, m_gnt(), m_busy(), 2'(m_oid), m_terr(r, d));
      model_step(r, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
